// File: rtl/clk_div_pkg.sv
// Shared constants and types for the programmable clock divider.
package clk_div_pkg;

  // Smallest ratio the divider accepts. A ratio of 1 would leave no low phase.
  localparam int DIV_MIN = 2;

  // Default counter width and the ratio in force after reset.
  localparam int CNT_W_DEF     = 8;
  localparam int DIV_RESET_DEF = 4;

  typedef logic [CNT_W_DEF-1:0] div_t;

endpackage

// File: rtl/div_shadow_reg.sv
// Shadow register for the divide ratio. It checks each load and holds the
// newest accepted ratio until the divider reaches a period boundary. The
// ratio is then handed over on the wrap edge, so clk_out never glitches.
module div_shadow_reg
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             wrap_i,
  output logic             apply_o,
  output logic [CNT_W-1:0] apply_val_o,
  output logic             ack_o,
  output logic             err_o
);

  logic             pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             load_ok;

  // A wrap applies whatever was pending before this edge. A load on the same
  // edge therefore becomes the next pending ratio.
  assign apply_o     = wrap_i & pend_valid_q;
  assign apply_val_o = pend_val_q;
  assign ack_o       = ack_q;
  assign err_o       = err_q;

  // Next-state for the pending ratio and the ack/err pulses
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_val_d   = pend_val_q;
    load_ok      = load_i && (load_val_i >= CNT_W'(DIV_MIN));
    err_d        = load_i && !load_ok;
    ack_d        = apply_o;
    if (apply_o) begin
      pend_valid_d = 1'b0;
    end
    if (load_ok) begin
      pend_valid_d = 1'b1;
      pend_val_d   = load_val_i;
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_val_q   <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_val_q   <= pend_val_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider. Divides clk_in by div_cur and produces
// a near-50% duty clk_out with a tick pulse on every period wrap. The fall of
// clk_out lines up with tick.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DIV_RESET = DIV_RESET_DEF
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             div_ack,
  output logic             div_err,
  output logic [CNT_W-1:0] div_cur
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_RESET);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic             apply;
  logic [CNT_W-1:0] apply_val;

  div_shadow_reg #(
    .CNT_W (CNT_W)
  ) u_shadow (
    .clk_in      (clk_in),
    .reset       (reset),
    .load_i      (div_load),
    .load_val_i  (div_val),
    .wrap_i      (wrap),
    .apply_o     (apply),
    .apply_val_o (apply_val),
    .ack_o       (div_ack),
    .err_o       (div_err)
  );

  // Period counter, ratio update and output generation.
  // clk_out is set from the values being registered on this edge. A restart
  // at cnt=0 under any legal ratio therefore always drives it low.
  always_comb begin
    cnt_d     = cnt_q;
    div_cur_d = div_cur_q;
    tick_d    = 1'b0;
    wrap      = enable && (cnt_q == (div_cur_q - ONE));
    if (enable) begin
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
    if (apply) begin
      div_cur_d = apply_val;
    end
    clk_out_d = (cnt_d >= (div_cur_d >> 1));
  end

  // Counter and output registers, cleared asynchronously
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      div_cur_q <= DIV_INIT;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign div_cur = div_cur_q;

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] div_val;
  logic       div_load;
  logic       clk_out;
  logic       tick;
  logic       div_ack;
  logic       div_err;
  logic [7:0] div_cur;

  int total = 0;
  int bad   = 0;

  // reference model: phase within period, period, pending ratio
  int m_ph, m_n, m_pend, m_pv;
  int m_clk, m_tick, m_ack, m_err;

  clk_div_prog #(.CNT_W(8), .DIV_RESET(4)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .enable   (enable),
    .div_val  (div_val),
    .div_load (div_load),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_ack  (div_ack),
    .div_err  (div_err),
    .div_cur  (div_cur)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit       en;
    bit       ld;
    bit [7:0] val;
    bit       e_clk;
    bit       e_tick;
    bit       e_ack;
    bit       e_err;
    int       e_cur;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_n = 4; m_pend = 0; m_pv = 0;
    m_clk = 0; m_tick = 0; m_ack = 0; m_err = 0;
  endtask

  // one rising edge of the reference behaviour
  task automatic model_edge(input bit en, input bit ld, input int v);
    bit wrap;
    wrap   = en && (m_ph == m_n - 1);
    m_tick = wrap;
    m_ack  = wrap && (m_pend != 0);
    m_err  = ld && (v < 2);
    if (wrap) begin
      if (m_pend != 0) begin
        m_n = m_pv;
        m_pend = 0;
      end
      m_ph = 0;
    end else if (en) begin
      m_ph = m_ph + 1;
    end
    if (ld && v >= 2) begin
      m_pv = v;
      m_pend = 1;
    end
    m_clk = (m_ph >= m_n / 2) ? 1 : 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".clk_out"}, clk_out, m_clk);
    chk({tag, ".tick"},    tick,    m_tick);
    chk({tag, ".div_ack"}, div_ack, m_ack);
    chk({tag, ".div_err"}, div_err, m_err);
    chk({tag, ".div_cur"}, div_cur, m_n);
  endtask

  task automatic edge_step(input bit en, input bit ld, input logic [7:0] v);
    enable = en; div_load = ld; div_val = v;
    @(posedge clk_in);
    model_edge(en, ld, int'(v));
    #1;
    div_load = 1'b0;
  endtask

  task automatic step(input bit en, input bit ld, input logic [7:0] v, input string tag);
    edge_step(en, ld, v);
    check_model(tag);
  endtask

  // reset pulse applied away from the clock edge
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_model("rst_async");
    @(posedge clk_in);
    #1;
    reset = 1'b0;
  endtask

  vec_t vecs[13];
  int   acks;
  int   lows, highs;
  bit   seen;
  int   cur_hold;

  initial begin
    reset = 1'b1; enable = 1'b0; div_load = 1'b0; div_val = '0;
    model_reset();
    #1;
    check_model("reset");
    @(posedge clk_in); #1;
    reset = 1'b0;

    // directed table: default ratio 4, then a load of 6 at cnt=1, then bad loads
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 4};
    vecs[1]  = '{1, 1, 6, 1, 0, 0, 0, 4};
    vecs[2]  = '{1, 0, 0, 1, 0, 0, 0, 4};
    vecs[3]  = '{1, 0, 0, 0, 1, 1, 0, 6};
    vecs[4]  = '{1, 0, 0, 0, 0, 0, 0, 6};
    vecs[5]  = '{1, 0, 0, 0, 0, 0, 0, 6};
    vecs[6]  = '{1, 0, 0, 1, 0, 0, 0, 6};
    vecs[7]  = '{1, 0, 0, 1, 0, 0, 0, 6};
    vecs[8]  = '{1, 0, 0, 1, 0, 0, 0, 6};
    vecs[9]  = '{1, 0, 0, 0, 1, 0, 0, 6};
    vecs[10] = '{1, 1, 1, 0, 0, 0, 1, 6};
    vecs[11] = '{1, 1, 0, 0, 0, 0, 1, 6};
    vecs[12] = '{1, 0, 0, 1, 0, 0, 0, 6};
    for (int i = 0; i < 13; i++) begin
      edge_step(vecs[i].en, vecs[i].ld, vecs[i].val);
      chk($sformatf("vec%0d.clk_out", i), clk_out, vecs[i].e_clk);
      chk($sformatf("vec%0d.tick", i),    tick,    vecs[i].e_tick);
      chk($sformatf("vec%0d.div_ack", i), div_ack, vecs[i].e_ack);
      chk($sformatf("vec%0d.div_err", i), div_err, vecs[i].e_err);
      chk($sformatf("vec%0d.div_cur", i), div_cur, vecs[i].e_cur);
    end

    // bad loads at ratio 4 leave it untouched and never ack
    do_reset();
    acks = 0;
    step(1, 1, 8'd1, "bad1");
    step(1, 1, 8'd0, "bad0");
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 8'd0, "bad_run");
      acks += div_ack;
    end
    chk("bad_no_ack", acks, 0);
    chk("bad_cur", div_cur, 4);

    // load 5 then 3 before the wrap: one ack, ratio 3
    do_reset();
    acks = 0;
    step(1, 1, 8'd5, "l53a");
    acks += div_ack;
    step(1, 1, 8'd3, "l53b");
    acks += div_ack;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 8'd0, "l53run");
      acks += div_ack;
    end
    chk("l53_single_ack", acks, 1);
    chk("l53_cur", div_cur, 3);

    // freeze with a pending ratio
    do_reset();
    step(1, 0, 8'd0, "frz_pre");
    step(1, 1, 8'd9, "frz_load");
    cur_hold = div_cur;
    for (int i = 0; i < 10; i++) step(0, 0, 8'd0, "frz_hold");
    chk("frz_cur", div_cur, cur_hold);
    for (int i = 0; i < 6; i++) step(1, 0, 8'd0, "frz_resume");
    chk("frz_applied", div_cur, 9);

    // reset mid-period discards a pending 255
    step(1, 1, 8'd255, "rst_load");
    step(1, 0, 8'd0, "rst_mid");
    do_reset();
    for (int i = 0; i < 12; i++) step(1, 0, 8'd0, "rst_after");
    chk("rst_cur", div_cur, 4);

    // ratio 255: 127 low, 128 high
    step(1, 1, 8'd255, "p255_load");
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1, 0, 8'd0, "p255_wait");
      seen = div_ack;
    end
    chk("p255_ack_seen", seen, 1);
    lows = 0; highs = 0;
    if (clk_out) highs++; else lows++;
    for (int i = 0; i < 254; i++) begin
      step(1, 0, 8'd0, "p255_run");
      if (clk_out) highs++; else lows++;
    end
    chk("p255_low", lows, 127);
    chk("p255_high", highs, 128);
    step(1, 0, 8'd0, "p255_wrap");
    chk("p255_tick", tick, 1);

    // randomized stimulus against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit en, ld;
      logic [7:0] v;
      en = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 15) == 0);
      v  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                       : 8'($urandom_range(0, 12));
      if (i == 1500) do_reset();
      step(en, ld, v, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Programmable integer clock divider for the clocking block.
- Divides clk_in by a runtime-loadable ratio N (2..2^CNT_W-1) and produces:
  - clk_out, a divided clock with a near-50% duty cycle.
  - tick, a one-cycle wrap pulse that serves as the enable for the downstream fixed divide-by-4 stage.
- Ratio changes go through a shadow register and take effect only at the period boundary, so clk_out never glitches.

Parameters:
- CNT_W, 8, width of the ratio and the period counter.
- DIV_RESET, 4, ratio in force after reset. Must satisfy 2 <= DIV_RESET <= 2^CNT_W-1.

Ports:
- clk_in  input  1  source clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high; clock clk_in.
- enable  input  1  count enable. When low, the divider freezes.
- div_val  input  CNT_W  requested ratio, sampled when div_load=1.
- div_load  input  1  one-cycle load strobe.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one clk_in-cycle pulse at each period wrap, registered.
- div_ack  output  1  one-cycle pulse: pending ratio has just been applied.
- div_err  output  1  one-cycle pulse: the load was rejected (div_val < 2).
- div_cur  output  CNT_W  ratio currently in force.

Behaviour:
- Reset values:
  - cnt = 0, clk_out = 0, tick = 0, div_ack = 0, div_err = 0.
  - div_cur = DIV_RESET.
  - pend_valid = 0, pend_val = 0.
- Counter, per edge when enable=1:
  - If cnt == div_cur-1: this is a wrap. cnt <= 0 and tick <= 1.
  - Otherwise: cnt <= cnt+1 and tick <= 0.
- clk_out <= (cnt_next >= div_cur_next >> 1), where cnt_next and div_cur_next are the values being registered on that edge.
  - Even N: N/2 cycles low, then N/2 cycles high.
  - Odd N: floor(N/2) cycles low, then ceil(N/2) cycles high.
  - The falling edge of clk_out coincides with tick.
- enable=0: cnt, clk_out and div_cur hold; tick <= 0. A pending ratio waits.
- Load, on an edge with div_load=1:
  - div_val >= 2: pend_val <= div_val, pend_valid <= 1. A load while a ratio is already pending overwrites it (last wins).
  - div_val < 2: div_err <= 1 for one cycle; the pending state is unchanged.
- Apply, at a wrap edge with pend_valid=1:
  - div_cur <= pend_val, pend_valid <= 0, div_ack <= 1 for one cycle.
  - cnt restarts at 0 under the new ratio, so clk_out stays low.
- Load and wrap on the same edge:
  - The previously pending value (if any) is applied on this edge.
  - The newly loaded value becomes pending and is applied at the next wrap.
  - If nothing was pending, the new value is applied at the next wrap.
- Latency: the first full period at the new ratio starts on the wrap edge that follows a load. The worst case is old N + 1 clk_in cycles after the load.
- Maximum ratio 2^CNT_W-1; cnt never exceeds div_cur-1, so no overflow is possible.
- Reset asserted mid-period: all state returns to reset values immediately (asynchronous), and any pending ratio is discarded.

Decomposition:
- Package clk_div_pkg holds:
  - DIV_MIN = 2.
  - Default CNT_W and DIV_RESET constants.
  - Typedef div_t = logic [CNT_W-1:0].
- One sub-module, div_shadow_reg. It contains:
  - Load validation and the div_err pulse.
  - The pend_val / pend_valid registers.
  - The apply handshake: it takes a wrap input and returns the apply strobe and the new value.
- The counter and clk_out/tick generation stay in clk_div_prog.

Test Plan:
- Release reset with enable=1 and no loads -> div_cur=4; clk_out repeats 0,0,1,1; tick high on every 4th edge, aligned with the clk_out fall.
- Load div_val=6 at cnt=1 -> no change until the wrap; at the wrap div_ack=1 and div_cur=6; then clk_out is 3 low / 3 high with tick every 6 cycles.
- Load div_val=1, then div_val=0 -> div_err pulses once per load; div_cur stays 4; no div_ack.
- Load 5, then load 3 before the wrap -> a single div_ack at the wrap, div_cur=3, clk_out 1 low / 2 high.
- Drop enable for 10 cycles mid-period with a load pending -> cnt, clk_out and div_cur frozen; tick=0; apply occurs at the first wrap after enable returns.
- Assert reset mid-period with a pending load of 255 -> outputs return to reset values immediately; after release the period is 4 and the pending ratio is gone. Separately, load 255 -> period 255: 127 low, 128 high.
